// File: rtl/conv_z_reader.sv
// conv_z_reader: streams result memory Z out over a valid/ready port.
// Walks Z from address 0 to z_len-1 through a 1-cycle-latency read port.
// Returned words go through a 2-entry output FIFO. The FIFO has a bypass
// path, so a word can be presented in the same cycle it leaves the RAM.
// Optional build macro: ZREAD_CLEAR_EN adds a write port (clr_we/clr_addr).
// That port zeroes each word of Z as it is handed downstream.
//
// state | meaning
// IDLE  | waiting for start; busy low
// RUN   | issuing reads while pointer < length and buffer space allows
// FLUSH | all reads issued (or empty run); draining until final beat
// DONE  | one-cycle done pulse, busy still high
module conv_z_reader #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   z_len,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] mem_addr_Z,
  input  logic [DATA_WIDTH-1:0] mem_data_Z,
  output logic                  rd_en,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_last
`ifdef ZREAD_CLEAR_EN
  ,
  output logic                  clr_we,
  output logic [ADDR_WIDTH-1:0] clr_addr
`endif
);

  localparam logic [ADDR_WIDTH:0] MAX_LEN = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] ONE     = {{ADDR_WIDTH{1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  state_t                state;
  logic [ADDR_WIDTH:0]   len;
  logic [ADDR_WIDTH:0]   rp;
  logic [ADDR_WIDTH:0]   sc;
  logic                  rd_d;
  logic [DATA_WIDTH-1:0] fifo_mem [2];
  logic                  wr_ptr;
  logic                  rd_ptr;
  logic [1:0]            count;

  logic                  fifo_empty;
  logic                  xfer;
  logic                  last_xfer;
  logic                  fifo_push;
  logic                  fifo_pop;
  logic [2:0]            occ_next;
  logic                  can_issue;
  logic [ADDR_WIDTH:0]   len_clamped;
  logic [DATA_WIDTH-1:0] head;

  // Stream side: FIFO head, or the word arriving from the RAM when the FIFO is empty
  always_comb begin
    fifo_empty  = (count == 2'd0);
    m_valid     = !fifo_empty || rd_d;
    head        = fifo_empty ? mem_data_Z : fifo_mem[rd_ptr];
    m_data      = m_valid ? head : '0;
    xfer        = m_valid && m_ready;
    m_last      = m_valid && (sc == len - ONE);
    last_xfer   = xfer && (sc == len - ONE);
    fifo_pop    = xfer && !fifo_empty;
    fifo_push   = rd_d && !(xfer && fifo_empty);
    // Words still held after this edge, plus the read on the bus now, must leave room
    occ_next    = {1'b0, count} + {2'b0, rd_d} - {2'b0, xfer};
    can_issue   = (rp < len) && ((occ_next + {2'b0, rd_en}) < 3'd2);
    len_clamped = (z_len > MAX_LEN) ? MAX_LEN : z_len;
    busy        = (state != IDLE);
    done        = (state == DONE);
  end

`ifdef ZREAD_CLEAR_EN
  // Zero each word of Z as it is transferred; sc is the address of the head word
  always_comb begin
    clr_we   = xfer;
    clr_addr = sc[ADDR_WIDTH-1:0];
  end
`endif

  // Sequencer: read pointer, sent counter and read strobe
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      len        <= '0;
      rp         <= '0;
      sc         <= '0;
      rd_en      <= 1'b0;
      rd_d       <= 1'b0;
      mem_addr_Z <= '0;
    end else begin
      rd_d <= rd_en;
      if (xfer) sc <= sc + ONE;
      case (state)
        IDLE: begin
          rd_en <= 1'b0;
          if (start) begin
            len <= len_clamped;
            sc  <= '0;
            if (len_clamped == '0) begin
              // Empty run still passes through FLUSH so done lands two cycles after start
              rp    <= '0;
              state <= FLUSH;
            end else begin
              rd_en      <= 1'b1;
              mem_addr_Z <= '0;
              rp         <= ONE;
              state      <= RUN;
            end
          end
        end
        RUN: begin
          if (can_issue) begin
            rd_en      <= 1'b1;
            mem_addr_Z <= rp[ADDR_WIDTH-1:0];
            rp         <= rp + ONE;
          end else begin
            rd_en <= 1'b0;
          end
          if (rp == len) state <= FLUSH;
        end
        FLUSH: begin
          rd_en <= 1'b0;
          if ((len == '0) || last_xfer) state <= DONE;
        end
        DONE: begin
          rd_en <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (fifo_push) wr_ptr <= ~wr_ptr;
      if (fifo_pop)  rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, fifo_push} - {1'b0, fifo_pop};
    end
  end

  // FIFO storage, no reset needed since count gates every read
  always_ff @(posedge clk) begin
    if (fifo_push) fifo_mem[wr_ptr] <= mem_data_Z;
  end

endmodule

// File: tb/tb_conv_z_reader.sv
// Testbench for conv_z_reader. Define ZREAD_CLEAR_EN to also cover the clear port.
module tb_conv_z_reader;
  localparam int DW = 16;
  localparam int AW = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW:0]   z_len;
  logic          busy, done, rd_en, m_valid, m_ready, m_last;
  logic [AW-1:0] mem_addr_Z;
  logic [DW-1:0] mem_data_Z;
  logic [DW-1:0] m_data;
`ifdef ZREAD_CLEAR_EN
  logic          clr_we;
  logic [AW-1:0] clr_addr;
`endif

  conv_z_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .z_len(z_len),
    .busy(busy), .done(done), .mem_addr_Z(mem_addr_Z), .mem_data_Z(mem_data_Z),
    .rd_en(rd_en), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .m_last(m_last)
`ifdef ZREAD_CLEAR_EN
    , .clr_we(clr_we), .clr_addr(clr_addr)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Z RAM model: word a holds a+1 (or 0xBEEF at 63 when big is set).
  // A clear marks the word with the current epoch; a new epoch restores the preload.
  int   clr_epoch [64];
  int   epoch = 1;
  logic big = 1'b0;

  function automatic logic [DW-1:0] zval(input int a);
    if (clr_epoch[a] == epoch) return '0;
    if (big && a == 63) return 16'hBEEF;
    return DW'(a + 1);
  endfunction

  always @(posedge clk) begin
    mem_data_Z <= zval(int'(mem_addr_Z));
`ifdef ZREAD_CLEAR_EN
    if (clr_we) clr_epoch[clr_addr] <= epoch;
`endif
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input bit ok, input string name, input int act, input int exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  logic [DW:0]   exp_q [$];
  int            issued = 0, accepted = 0, iss_base = 0, acc_base = 0;
  int            done_cnt = 0, clr_cnt = 0;
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data = '0;
  logic          tog_mode = 1'b0;

  // Monitor / scoreboard
  always @(negedge clk) begin
    logic [DW:0] e;
    if (rd_en) begin
      chk(int'(mem_addr_Z) == issued - iss_base, "read_addr", int'(mem_addr_Z), issued - iss_base);
      issued++;
      chk((issued - iss_base) - (accepted - acc_base) <= 2, "reads_ahead",
          (issued - iss_base) - (accepted - acc_base), 2);
    end
    if (prev_stall)
      chk(m_valid && m_data == prev_data, "stall_hold", int'(m_data), int'(prev_data));
    if (m_valid && m_ready) begin
      if (exp_q.size() == 0) begin
        chk(1'b0, "extra_beat", int'(m_data), 0);
      end else begin
        e = exp_q.pop_front();
        chk(m_data == e[DW-1:0], "beat_data", int'(m_data), int'(e[DW-1:0]));
        chk(m_last == e[DW], "beat_last", int'(m_last), int'(e[DW]));
      end
`ifdef ZREAD_CLEAR_EN
      chk(clr_we && int'(clr_addr) == accepted - acc_base, "clr_addr", int'(clr_addr), accepted - acc_base);
`endif
      accepted++;
    end
`ifdef ZREAD_CLEAR_EN
    if (clr_we) begin
      clr_cnt++;
      if (!(m_valid && m_ready)) chk(1'b0, "clr_without_xfer", 1, 0);
    end
`endif
    if (done) begin
      done_cnt++;
      chk(!m_valid, "done_vs_valid", int'(m_valid), 0);
    end
    prev_stall = m_valid && !m_ready && !rst;
    prev_data  = m_data;
  end

  // Consumer ready: always 1, or the repeating 1,0,0,1 pattern
  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (tog_mode) m_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
      else          m_ready = 1'b1;
    end
  end

  task automatic push_expected(input int lc);
    logic [DW-1:0] v;
    for (int i = 0; i < lc; i++) begin
      v = (big && i == 63) ? 16'hBEEF : DW'(i + 1);
      exp_q.push_back({(i == lc - 1), v});
    end
  endtask

  task automatic begin_run(input int len, input bit toggle, output int t0);
    int lc;
    lc = (len > 64) ? 64 : len;
    epoch++;
    push_expected(lc);
    iss_base = issued;
    acc_base = accepted;
    tog_mode = toggle;
    @(posedge clk); #1;
    start = 1'b1;
    z_len = (AW+1)'(len);
    t0 = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    z_len = 7'h55;
    if (len >= 4) begin
      @(posedge clk); #1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
    end
  endtask

  task automatic run(input int len, input bit toggle, input int lat);
    int t0, lc;
    bit seen;
    lc = (len > 64) ? 64 : len;
    begin_run(len, toggle, t0);
    seen = 1'b0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    chk(seen, "done_seen", int'(seen), 1);
    if (seen && lat >= 0) chk(cyc - t0 == lat, "done_cycle", cyc - t0, lat);
    chk(exp_q.size() == 0, "beats_all", exp_q.size(), 0);
    chk(issued - iss_base == lc, "reads_issued", issued - iss_base, lc);
    @(negedge clk);
    chk(!busy && !done, "idle_after_done", int'({busy, done}), 0);
    tog_mode = 1'b0;
  endtask

  initial begin
    int t0, dcnt, cbase;
    bit hit;
    rst = 1'b1; start = 1'b0; z_len = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk({busy, done, rd_en, m_valid, m_last} == 5'b0, "reset_ctrl", int'({busy, done, rd_en, m_valid, m_last}), 0);
    chk(mem_addr_Z == '0 && m_data == '0, "reset_data", int'(m_data), 0);
    @(posedge clk); #1;
    rst = 1'b0;

    run(19, 1'b0, 21);
    run(19, 1'b1, -1);
    run(0, 1'b0, 2);
    big = 1'b1;
    run(64, 1'b0, 66);
    run(100, 1'b0, 66);
    big = 1'b0;

    // Reset in the middle of a 19-word run
    begin_run(19, 1'b0, t0);
    hit = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if (accepted - acc_base >= 5) begin
        hit = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk(hit, "reach_beat5", accepted - acc_base, 5);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk({busy, done, rd_en, m_valid, m_last} == 5'b0, "midrun_rst_ctrl", int'({busy, done, rd_en, m_valid, m_last}), 0);
    chk(mem_addr_Z == '0 && m_data == '0, "midrun_rst_data", int'(m_data), 0);
    dcnt = done_cnt;
    repeat (5) @(negedge clk);
    chk(done_cnt == dcnt, "no_done_after_rst", done_cnt - dcnt, 0);
    exp_q.delete();

    run(19, 1'b0, 21);

`ifdef ZREAD_CLEAR_EN
    cbase = clr_cnt;
    run(10, 1'b0, 12);
    chk(clr_cnt - cbase == 10, "clr_we_cycles", clr_cnt - cbase, 10);
    for (int i = 0; i < 10; i++) chk(zval(i) == '0, "z_cleared", int'(zval(i)), 0);
    chk(zval(10) == 16'h000B, "z_untouched", int'(zval(10)), 16'h000B);
`else
    cbase = 0;
`endif

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks + cbase * 0);
    $finish;
  end

endmodule
